// File: rtl/ddr_arb_pkg.sv
// Shared types and constants for the DDR port arbiter.
package ddr_arb_pkg;

    localparam int DEF_DDR_DATA_WIDTH = 128;
    localparam int DEF_ADDR_WIDTH     = 24;
    localparam int DEF_MAX_WR_BURST   = 8;
    localparam int DEF_RD_TIMEOUT     = 255;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE_WR = 2'd1,
        ISSUE_RD = 2'd2,
        WAIT_RD  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/ddr_port_arbiter.sv
// Two-port (writer/reader) arbiter in front of a DDR user command interface,
// with write-burst fairness and a sticky read-timeout flag.
//
// state    | meaning
// IDLE     | no command in flight; arbitrate and latch the winner's addr/data
// ISSUE_WR | write command + write data presented until both DDR readies
// ISSUE_RD | read command presented until ddr_cmd_rdy
// WAIT_RD  | one read outstanding; wait for read data or timeout
module ddr_port_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int DDR_DATA_WIDTH = DEF_DDR_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int MAX_WR_BURST   = DEF_MAX_WR_BURST,
    parameter int RD_TIMEOUT     = DEF_RD_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_req,
    input  logic [ADDR_WIDTH-1:0]     wr_addr,
    input  logic [DDR_DATA_WIDTH-1:0] wr_data,
    output logic                      wr_ack,
    input  logic                      rd_req,
    input  logic [ADDR_WIDTH-1:0]     rd_addr,
    output logic                      rd_ack,
    output logic                      rd_data_valid,
    input  logic                      ddr_cmd_rdy,
    output logic                      ddr_cmd_en,
    output logic [2:0]                ddr_cmd,
    output logic [ADDR_WIDTH-1:0]     ddr_addr,
    input  logic                      ddr_wdf_rdy,
    output logic                      ddr_wdf_wren,
    output logic [DDR_DATA_WIDTH-1:0] ddr_wdf_data,
    input  logic                      ddr_rd_data_valid,
    output logic                      timeout_err
);

    localparam int BW = $clog2(MAX_WR_BURST + 1);
    localparam int TW = $clog2(RD_TIMEOUT + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_WR_BURST);
    localparam logic [TW-1:0] TO_LAST   = TW'(RD_TIMEOUT - 1);

    arb_state_t                r_state;
    arb_state_t                w_next;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [DDR_DATA_WIDTH-1:0] r_data;
    logic [BW-1:0]             r_wr_burst_cnt;
    logic [TW-1:0]             r_to_cnt;
    logic                      r_timeout_err;
    logic                      r_early_valid;
    logic                      w_rd_valid;
    logic                      w_to_hit;

    // A valid that arrived together with the read command acceptance is held
    // one cycle so it can be forwarded from WAIT_RD.
    assign w_rd_valid   = ddr_rd_data_valid | r_early_valid;
    assign w_to_hit     = (r_to_cnt == TO_LAST);
    assign ddr_addr     = r_addr;
    assign ddr_wdf_data = r_data;
    assign timeout_err  = r_timeout_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (wr_req && rd_req)
                    w_next = (r_wr_burst_cnt == BURST_MAX) ? ISSUE_RD : ISSUE_WR;
                else if (wr_req)
                    w_next = ISSUE_WR;
                else if (rd_req)
                    w_next = ISSUE_RD;
            end
            ISSUE_WR: if (ddr_cmd_rdy && ddr_wdf_rdy) w_next = IDLE;
            ISSUE_RD: if (ddr_cmd_rdy) w_next = WAIT_RD;
            WAIT_RD:  if (w_rd_valid || w_to_hit) w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_comb begin
        wr_ack        = 1'b0;
        rd_ack        = 1'b0;
        rd_data_valid = 1'b0;
        ddr_cmd_en    = 1'b0;
        ddr_cmd       = CMD_WRITE;
        ddr_wdf_wren  = 1'b0;
        case (r_state)
            ISSUE_WR: begin
                ddr_cmd_en   = 1'b1;
                ddr_wdf_wren = 1'b1;
                wr_ack       = ddr_cmd_rdy & ddr_wdf_rdy;
            end
            ISSUE_RD: begin
                ddr_cmd_en = 1'b1;
                ddr_cmd    = CMD_READ;
                rd_ack     = ddr_cmd_rdy;
            end
            WAIT_RD:  rd_data_valid = w_rd_valid;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr         <= '0;
            r_data         <= '0;
            r_wr_burst_cnt <= '0;
            r_to_cnt       <= '0;
            r_timeout_err  <= 1'b0;
            r_early_valid  <= 1'b0;
        end else begin
            if (r_state == IDLE) begin
                if (w_next == ISSUE_WR) begin
                    r_addr <= wr_addr;
                    r_data <= wr_data;
                end else if (w_next == ISSUE_RD) begin
                    r_addr <= rd_addr;
                end
            end

            if (rd_ack || (r_state == IDLE && !wr_req))
                r_wr_burst_cnt <= '0;
            else if (wr_ack && r_wr_burst_cnt != BURST_MAX)
                r_wr_burst_cnt <= r_wr_burst_cnt + 1'b1;

            if (rd_ack)
                r_to_cnt <= '0;
            else if (r_state == WAIT_RD)
                r_to_cnt <= r_to_cnt + 1'b1;

            if (r_state == WAIT_RD && !w_rd_valid && w_to_hit)
                r_timeout_err <= 1'b1;

            if (r_state == ISSUE_RD && ddr_cmd_rdy && ddr_rd_data_valid)
                r_early_valid <= 1'b1;
            else if (r_state == WAIT_RD)
                r_early_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Self-checking bench for ddr_port_arbiter: per-cycle vector table, a grant
// scoreboard under contention, and timeout / mid-read reset sequences.
module tb_ddr_port_arbiter;
    import ddr_arb_pkg::*;

    localparam int DW = 128;
    localparam int AW = 24;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_req, rd_req, wr_ack, rd_ack, rd_data_valid;
    logic [AW-1:0] wr_addr, rd_addr, ddr_addr;
    logic [DW-1:0] wr_data, ddr_wdf_data;
    logic          ddr_cmd_rdy, ddr_cmd_en, ddr_wdf_rdy, ddr_wdf_wren;
    logic          ddr_rd_data_valid, timeout_err;
    logic [2:0]    ddr_cmd;

    ddr_port_arbiter dut (
        .clk(clk), .reset(reset),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data_valid(rd_data_valid),
        .ddr_cmd_rdy(ddr_cmd_rdy), .ddr_cmd_en(ddr_cmd_en), .ddr_cmd(ddr_cmd),
        .ddr_addr(ddr_addr), .ddr_wdf_rdy(ddr_wdf_rdy), .ddr_wdf_wren(ddr_wdf_wren),
        .ddr_wdf_data(ddr_wdf_data), .ddr_rd_data_valid(ddr_rd_data_valid),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {cmd_en, cmd[2:0], wdf_wren, wr_ack, rd_ack, rd_data_valid}
    function automatic logic [7:0] outs();
        return {ddr_cmd_en, ddr_cmd, ddr_wdf_wren, wr_ack, rd_ack, rd_data_valid};
    endfunction

    function automatic logic [DW-1:0] dpat(input int k);
        return {4{32'hC0DE_0000 | 32'(k)}};
    endfunction

    // in = {wr_req, rd_req, ddr_cmd_rdy, ddr_wdf_rdy, ddr_rd_data_valid}
    typedef struct packed {
        logic [4:0] in;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        bit            is_rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } grant_t;

    localparam int NV = 31;
    vec_t   vecs[NV];
    grant_t sb[$];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        grant_t g;
        int     wi, ri, cyc, c;
        bit     dv_next;

        vecs[0]  = {5'b00000, 8'b0000_0000};
        vecs[1]  = {5'b10110, 8'b0000_0000};
        vecs[2]  = {5'b10110, 8'b1000_1100};   // single write acked at N+1
        vecs[3]  = {5'b00110, 8'b0000_0000};
        vecs[4]  = {5'b10100, 8'b0000_0000};
        vecs[5]  = {5'b10100, 8'b1000_1000};   // write FIFO not ready
        vecs[6]  = {5'b10100, 8'b1000_1000};
        vecs[7]  = {5'b10100, 8'b1000_1000};
        vecs[8]  = {5'b10100, 8'b1000_1000};
        vecs[9]  = {5'b10010, 8'b1000_1000};   // cmd not ready
        vecs[10] = {5'b10110, 8'b1000_1100};
        vecs[11] = {5'b00110, 8'b0000_0000};
        vecs[12] = {5'b01000, 8'b0000_0000};
        vecs[13] = {5'b01000, 8'b1001_0000};
        vecs[14] = {5'b01100, 8'b1001_0010};
        vecs[15] = {5'b00000, 8'b0000_0000};
        vecs[16] = {5'b00000, 8'b0000_0000};
        vecs[17] = {5'b00000, 8'b0000_0000};
        vecs[18] = {5'b00000, 8'b0000_0000};
        vecs[19] = {5'b00001, 8'b0000_0001};   // data 5 cycles after rd_ack
        vecs[20] = {5'b00001, 8'b0000_0000};   // stray valid in IDLE
        vecs[21] = {5'b01000, 8'b0000_0000};
        vecs[22] = {5'b01101, 8'b1001_0010};   // accept and valid together
        vecs[23] = {5'b00000, 8'b0000_0001};
        vecs[24] = {5'b00000, 8'b0000_0000};
        vecs[25] = {5'b11110, 8'b0000_0000};
        vecs[26] = {5'b11110, 8'b1000_1100};
        vecs[27] = {5'b01110, 8'b0000_0000};
        vecs[28] = {5'b01110, 8'b1001_0010};
        vecs[29] = {5'b00001, 8'b0000_0001};
        vecs[30] = {5'b00000, 8'b0000_0000};

        reset = 1'b1;
        wr_req = 1'b1; rd_req = 1'b1;
        ddr_cmd_rdy = 1'b1; ddr_wdf_rdy = 1'b1; ddr_rd_data_valid = 1'b1;
        wr_addr = 24'h10; rd_addr = 24'h20; wr_data = {16{8'hA5}};
        #12;
        chk("reset_outs", 128'(outs()), 128'(8'h00));
        chk("reset_timeout_err", 128'(timeout_err), 128'(1'b0));
        chk("reset_addr", 128'(ddr_addr), 128'(0));
        chk("reset_wdf_data", 128'(ddr_wdf_data), 128'(0));
        wr_req = 1'b0; rd_req = 1'b0;
        ddr_cmd_rdy = 1'b0; ddr_wdf_rdy = 1'b0; ddr_rd_data_valid = 1'b0;
        tick();
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            tick();
            {wr_req, rd_req, ddr_cmd_rdy, ddr_wdf_rdy, ddr_rd_data_valid} = vecs[i].in;
            #1;
            chk($sformatf("vec%0d", i), 128'(outs()), 128'(vecs[i].exp));
            if (vecs[i].exp[7])
                chk($sformatf("vec%0d_addr", i), 128'(ddr_addr),
                    128'(vecs[i].exp[4] ? 24'h20 : 24'h10));
            if (vecs[i].exp[3])
                chk($sformatf("vec%0d_data", i), ddr_wdf_data, {16{8'hA5}});
        end

        // Contention: both held; expect 8 writes then 1 read, twice.
        wi = 0; ri = 0;
        for (int rep = 0; rep < 2; rep++) begin
            for (int k = 0; k < 8; k++) begin
                sb.push_back('{1'b0, AW'(24'h100 + wi), dpat(wi)});
                wi++;
            end
            sb.push_back('{1'b1, AW'(24'h200 + ri), '0});
            ri++;
        end
        wi = 0; ri = 0; cyc = 0; dv_next = 1'b0;
        while (sb.size() > 0 && cyc < 100) begin
            tick();
            cyc++;
            wr_req = 1'b1; rd_req = 1'b1; ddr_cmd_rdy = 1'b1; ddr_wdf_rdy = 1'b1;
            wr_addr = AW'(24'h100 + wi); wr_data = dpat(wi); rd_addr = AW'(24'h200 + ri);
            ddr_rd_data_valid = dv_next;
            dv_next = 1'b0;
            #1;
            if (wr_ack || rd_ack) begin
                g = sb.pop_front();
                chk("grant_kind", 128'(rd_ack), 128'(g.is_rd));
                chk("grant_addr", 128'(ddr_addr), 128'(g.addr));
                if (!g.is_rd) chk("grant_data", ddr_wdf_data, g.data);
                if (wr_ack) wi++;
                if (rd_ack) begin
                    ri++;
                    dv_next = 1'b1;
                end
            end
        end
        chk("contention_done", 128'(sb.size()), 128'(0));
        tick();
        wr_req = 1'b0; rd_req = 1'b0; ddr_rd_data_valid = dv_next;
        tick();
        ddr_rd_data_valid = 1'b0;
        tick();

        // Timeout: read accepted, no data ever returns.
        tick();
        rd_req = 1'b1; rd_addr = 24'h2A; ddr_cmd_rdy = 1'b1; ddr_rd_data_valid = 1'b0;
        #1;
        c = 0;
        while (!rd_ack && c < 10) begin
            tick();
            c++;
        end
        chk("to_rd_ack", 128'(rd_ack), 128'(1'b1));
        tick();
        rd_req = 1'b0;
        for (int j = 2; j <= 254; j++) tick();
        tick();
        chk("to_err_before", 128'(timeout_err), 128'(1'b0));
        tick();
        ddr_rd_data_valid = 1'b1;
        #1;
        chk("to_err_after", 128'(timeout_err), 128'(1'b1));
        chk("to_stray_valid", 128'(rd_data_valid), 128'(1'b0));
        chk("to_idle_cmd_en", 128'(ddr_cmd_en), 128'(1'b0));
        tick();
        ddr_rd_data_valid = 1'b0; wr_req = 1'b1; wr_addr = 24'h33; ddr_wdf_rdy = 1'b1;
        #1;
        chk("to_idle_req", 128'(outs()), 128'(8'h00));
        tick();
        chk("to_then_write", 128'(outs()), 128'(8'b1000_1100));
        chk("to_then_write_addr", 128'(ddr_addr), 128'(24'h33));
        tick();
        wr_req = 1'b0;
        #1;
        chk("to_err_sticky", 128'(timeout_err), 128'(1'b1));

        // Reset in the middle of WAIT_RD.
        tick();
        rd_req = 1'b1; rd_addr = 24'h44;
        tick();
        chk("rst_rd_ack", 128'(rd_ack), 128'(1'b1));
        tick();
        rd_req = 1'b0;
        tick();
        #1;
        reset = 1'b1; ddr_rd_data_valid = 1'b1; wr_req = 1'b1;
        #1;
        chk("rst_mid_outs", 128'(outs()), 128'(8'h00));
        chk("rst_mid_err", 128'(timeout_err), 128'(1'b0));
        chk("rst_mid_addr", 128'(ddr_addr), 128'(0));
        tick();
        chk("rst_hold_outs", 128'(outs()), 128'(8'h00));
        reset = 1'b0; wr_req = 1'b0; ddr_rd_data_valid = 1'b0;
        tick();
        chk("rst_after_idle", 128'(outs()), 128'(8'h00));
        tick();
        ddr_rd_data_valid = 1'b1;
        #1;
        chk("rst_after_stray", 128'(rd_data_valid), 128'(1'b0));
        ddr_rd_data_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ddr_port_arbiter.md
DDR_PORT_ARBITER -- requirements
Module: ddr_port_arbiter

Interface
REQ-001 SHALL have parameter DDR_DATA_WIDTH, default 128, DDR user data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 24, DDR user address width.
REQ-003 SHALL have parameter MAX_WR_BURST, default 8, consecutive write grants allowed while a read is pending.
REQ-004 SHALL have parameter RD_TIMEOUT, default 255, WAIT_RD cycles before timeout.
REQ-005 SHALL have one clock and asynchronous active-high reset: clk  in  1  system clock; reset  in  1  async active-high reset.
REQ-006 SHALL have the writer ports: wr_req  in  1  write request; wr_addr  in  ADDR_WIDTH  write address; wr_data  in  DDR_DATA_WIDTH  write data; wr_ack  out  1  write accepted pulse.
REQ-007 SHALL have the reader ports: rd_req  in  1  read request; rd_addr  in  ADDR_WIDTH  read address; rd_ack  out  1  read accepted pulse; rd_data_valid  out  1  read data valid to the reader.
REQ-008 SHALL have the DDR command ports: ddr_cmd_rdy  in  1  DDR accepts command; ddr_cmd_en  out  1  command valid; ddr_cmd  out  3  command code; ddr_addr  out  ADDR_WIDTH  command address.
REQ-009 SHALL have the DDR data ports: ddr_wdf_rdy  in  1  write FIFO ready; ddr_wdf_wren  out  1  write data valid; ddr_wdf_data  out  DDR_DATA_WIDTH  write data; ddr_rd_data_valid  in  1  DDR read data valid.
REQ-010 SHALL have timeout_err  out  1  sticky read-timeout flag.

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE_WR, ISSUE_RD, WAIT_RD.
REQ-012 Requesters SHALL hold req, addr and data stable until their ack; the arbiter SHALL latch addr/data into registers on the IDLE grant cycle.
REQ-013 IDLE with only wr_req SHALL go to ISSUE_WR; with only rd_req, to ISSUE_RD; with neither, stay in IDLE.
REQ-014 IDLE with both requests SHALL go to ISSUE_RD when wr_burst_cnt == MAX_WR_BURST, otherwise to ISSUE_WR.
REQ-015 wr_burst_cnt SHALL increment on each wr_ack, saturate at MAX_WR_BURST, and clear on rd_ack or when wr_req is low in IDLE.
REQ-016 ISSUE_WR SHALL drive ddr_cmd_en=1, ddr_cmd=CMD_WRITE and ddr_wdf_wren=1 with the latched address/data.
REQ-017 ISSUE_WR SHALL complete only in a cycle where ddr_cmd_rdy and ddr_wdf_rdy are both 1; that cycle SHALL assert wr_ack for one cycle and the next state SHALL be IDLE.
REQ-018 ISSUE_RD SHALL drive ddr_cmd_en=1 and ddr_cmd=CMD_READ until ddr_cmd_rdy; that cycle SHALL assert rd_ack for one cycle and the next state SHALL be WAIT_RD, clearing the timeout counter.
REQ-019 WAIT_RD SHALL pass rd_data_valid = ddr_rd_data_valid and return to IDLE on the first valid; at most one read SHALL be outstanding.
REQ-020 WAIT_RD SHALL increment the timeout counter every cycle; on reaching RD_TIMEOUT it SHALL set timeout_err and return to IDLE.
REQ-021 rd_data_valid SHALL be 0 outside WAIT_RD; a stray ddr_rd_data_valid outside WAIT_RD SHALL be dropped.
REQ-022 Latency: a request seen in IDLE at cycle N SHALL give ddr_cmd_en=1 at N+1; the ack SHALL come no earlier than N+1.
REQ-023 ddr_cmd_en and ddr_wdf_wren SHALL be 0 in IDLE and WAIT_RD.
REQ-024 If ddr_cmd_rdy and ddr_rd_data_valid occur together in ISSUE_RD, the arbiter SHALL enter WAIT_RD and forward that valid.

Reset
REQ-025 Reset SHALL asynchronously force IDLE and clear wr_burst_cnt, the timeout counter, timeout_err and all address/data registers.
REQ-026 During reset, wr_ack, rd_ack, rd_data_valid, ddr_cmd_en and ddr_wdf_wren SHALL be 0, and ddr_cmd SHALL be CMD_WRITE.
REQ-027 A reset during ISSUE_* or WAIT_RD SHALL abandon the transaction without an ack; the requester SHALL re-request.

Structure
REQ-028 Package ddr_arb_pkg SHALL hold the state enum, CMD_WRITE=3'b000, CMD_READ=3'b001, and the parameter defaults.
REQ-029 The block SHALL be a single module with no sub-modules; the counters and FSM SHALL be inline.

Verification
REQ-030 Single write: wr_req, addr 0x10, data 0xA5.., rdy=1 -> cmd_en at N+1, cmd=000, addr 0x10, wr_ack at N+1, IDLE at N+2.
REQ-031 Read: rd_req addr 0x20, ddr_rd_data_valid 5 cycles after rd_ack -> rd_ack once, rd_data_valid once, return to IDLE.
REQ-032 Contention: both requests held continuously -> grant order 8 writes, 1 read, repeating.
REQ-033 Backpressure: ddr_wdf_rdy=0 for 4 cycles with ddr_cmd_rdy=1 -> stays in ISSUE_WR, wr_ack only when both rdy are 1.
REQ-034 Timeout: read with no valid -> timeout_err=1 after 255 WAIT_RD cycles, IDLE; a later valid is dropped.
REQ-035 Reset asserted mid-WAIT_RD -> immediately IDLE, all outputs 0, timeout_err cleared.
